// File: rtl/jtbubl_work_arb_pkg.sv
// Shared definitions for the JTBUBL work-RAM arbiter: owner states and phase constants.
// Latency: n/a (definitions only).
// Backpressure: n/a (definitions only).
package jtbubl_work_arb_pkg;

   // Owner of the RAM port; the encoding is reused by the comm-RAM arbiter.
   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_MAIN = 2'd1,
      ST_SUB  = 2'd2
   } arb_state_t;

   // Phase value at which ram_q holds the owner's read data.
   localparam logic [1:0] PHASE_DATA = 2'd2;

   // {sub,main} one-hot owner flags for status output.
   function automatic logic [1:0] state_grant(input arb_state_t s);
      return {s == ST_SUB, s == ST_MAIN};
   endfunction

endpackage

// File: rtl/jtbubl_work_arb.sv
// Time-shares the 8kB work RAM between main and sub Z80s, one grant per CPU access.
// Latency: uncontended read data registered 2 clk after the grant edge (3 clk after cs).
// Backpressure: a requesting CPU is held in WAIT (wait_n low) until its data is registered.
module jtbubl_work_arb
   import jtbubl_work_arb_pkg::*;
#(
   parameter int AW   = 13,
   parameter int PRIO = 0
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          main_cs,
   input  logic          main_wrn,
   input  logic [AW-1:0] main_addr,
   input  logic [7:0]    main_din,
   output logic [7:0]    main_dout,
   output logic          main_wait_n,
   input  logic          sub_en,
   input  logic          sub_cs,
   input  logic          sub_wrn,
   input  logic [AW-1:0] sub_addr,
   input  logic [7:0]    sub_din,
   output logic [7:0]    sub_dout,
   output logic          sub_wait_n,
   output logic [AW-1:0] ram_addr,
   output logic [7:0]    ram_din,
   output logic          ram_we,
   input  logic [7:0]    ram_q,
   output logic [1:0]    grant
);

   arb_state_t state_q, state_d;
   logic [1:0] phase_q, phase_d;
   logic       rdy_q, rdy_d;
   logic       wr_done_q, wr_done_d;
   logic       last_sub_q, last_sub_d;
   logic [7:0] main_dout_q, main_dout_d;
   logic [7:0] sub_dout_q, sub_dout_d;
   logic       sub_req;
   logic       state_chg;
   logic       we_c;

   // A sub CPU held in reset cannot own the RAM, even mid-access.
   assign sub_req   = sub_cs & sub_en;
   assign state_chg = (state_d != state_q);

   // Owner selection; last_sub tracks who won the previous tie so ties alternate.
   always_comb begin
      state_d    = state_q;
      last_sub_d = last_sub_q;
      case (state_q)
         ST_IDLE: begin
            if (main_cs && sub_req) begin
               if ((PRIO != 0) || last_sub_q) begin
                  state_d    = ST_MAIN;
                  last_sub_d = 1'b0;
               end else begin
                  state_d    = ST_SUB;
                  last_sub_d = 1'b1;
               end
            end else if (main_cs) begin
               state_d = ST_MAIN;
            end else if (sub_req) begin
               state_d = ST_SUB;
            end
         end
         ST_MAIN: begin
            if (!main_cs) state_d = sub_req ? ST_SUB : ST_IDLE;
         end
         ST_SUB: begin
            if (!sub_req) state_d = main_cs ? ST_MAIN : ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // RAM port mux; the write strobe is gated by the owner's select so a
   // dropping request can never write, and by wr_done for one write per access.
   always_comb begin
      ram_addr = main_addr;
      ram_din  = main_din;
      we_c     = 1'b0;
      case (state_q)
         ST_MAIN: we_c = main_cs & ~main_wrn;
         ST_SUB: begin
            ram_addr = sub_addr;
            ram_din  = sub_din;
            we_c     = sub_req & ~sub_wrn;
         end
         default: we_c = 1'b0;
      endcase
      we_c = we_c & ~wr_done_q;
   end

   // Access sequencing: phase restarts on every owner change. From phase 1 on,
   // ram_q reflects the owner's address, so it is captured each edge; later
   // captures pick up data written earlier in the same access.
   always_comb begin
      phase_d     = phase_q;
      rdy_d       = rdy_q;
      wr_done_d   = wr_done_q;
      main_dout_d = main_dout_q;
      sub_dout_d  = sub_dout_q;
      if (state_chg) begin
         phase_d   = 2'd0;
         rdy_d     = 1'b0;
         wr_done_d = 1'b0;
      end else begin
         if (phase_q != PHASE_DATA) phase_d = phase_q + 2'd1;
         if (we_c) wr_done_d = 1'b1;
         if (phase_q != 2'd0) begin
            if (state_q == ST_MAIN) begin
               main_dout_d = ram_q;
               rdy_d       = 1'b1;
            end else if (state_q == ST_SUB) begin
               sub_dout_d  = ram_q;
               rdy_d       = 1'b1;
            end
         end
      end
   end

   // State registers; reset makes main win the first tie.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         phase_q     <= 2'd0;
         rdy_q       <= 1'b0;
         wr_done_q   <= 1'b0;
         last_sub_q  <= 1'b1;
         main_dout_q <= 8'hFF;
         sub_dout_q  <= 8'hFF;
      end else begin
         state_q     <= state_d;
         phase_q     <= phase_d;
         rdy_q       <= rdy_d;
         wr_done_q   <= wr_done_d;
         last_sub_q  <= last_sub_d;
         main_dout_q <= main_dout_d;
         sub_dout_q  <= sub_dout_d;
      end
   end

   assign main_wait_n = ~(main_cs & ~((state_q == ST_MAIN) & rdy_q));
   assign sub_wait_n  = ~(sub_req & ~((state_q == ST_SUB) & rdy_q));
   assign main_dout   = main_dout_q;
   assign sub_dout    = sub_dout_q;
   assign ram_we      = we_c;
   assign grant       = state_grant(state_q);

endmodule

// File: tb/tb_jtbubl_work_arb.sv
// Bench for jtbubl_work_arb: directed vectors, tie/priority sequences, random traffic.
// Latency: n/a.
// Backpressure: the bench behaves like a Z80, holding each access until wait_n is high.
module tb_jtbubl_work_arb;
   localparam int AW = 13;

   logic          clk;
   logic          rst_n;
   logic          main_cs, main_wrn, sub_en, sub_cs, sub_wrn;
   logic [AW-1:0] main_addr, sub_addr;
   logic [7:0]    main_din, sub_din;

   logic [7:0]    main_dout0, sub_dout0, ram_din0, q0;
   logic          main_wait_n0, sub_wait_n0, ram_we0;
   logic [AW-1:0] ram_addr0;
   logic [1:0]    grant0;
   logic [7:0]    main_dout1, sub_dout1, ram_din1, q1;
   logic          main_wait_n1, sub_wait_n1, ram_we1;
   logic [AW-1:0] ram_addr1;
   logic [1:0]    grant1;

   logic [7:0]    mem0    [0:8191];
   logic [7:0]    mem1    [0:8191];
   logic [7:0]    ref_mem [0:8191];

   int            checks = 0;
   int            errors = 0;
   int            we_cnt0 = 0;
   logic [AW-1:0] we_addr0;
   int            wr_total = 0;

   jtbubl_work_arb #(.AW(AW), .PRIO(0)) u0 (
      .clk(clk), .rst_n(rst_n),
      .main_cs(main_cs), .main_wrn(main_wrn), .main_addr(main_addr), .main_din(main_din),
      .main_dout(main_dout0), .main_wait_n(main_wait_n0),
      .sub_en(sub_en), .sub_cs(sub_cs), .sub_wrn(sub_wrn), .sub_addr(sub_addr), .sub_din(sub_din),
      .sub_dout(sub_dout0), .sub_wait_n(sub_wait_n0),
      .ram_addr(ram_addr0), .ram_din(ram_din0), .ram_we(ram_we0), .ram_q(q0), .grant(grant0));

   jtbubl_work_arb #(.AW(AW), .PRIO(1)) u1 (
      .clk(clk), .rst_n(rst_n),
      .main_cs(main_cs), .main_wrn(main_wrn), .main_addr(main_addr), .main_din(main_din),
      .main_dout(main_dout1), .main_wait_n(main_wait_n1),
      .sub_en(sub_en), .sub_cs(sub_cs), .sub_wrn(sub_wrn), .sub_addr(sub_addr), .sub_din(sub_din),
      .sub_dout(sub_dout1), .sub_wait_n(sub_wait_n1),
      .ram_addr(ram_addr1), .ram_din(ram_din1), .ram_we(ram_we1), .ram_q(q1), .grant(grant1));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Synchronous RAMs with one-clock read latency (read-before-write).
   always @(posedge clk) begin
      q0 <= mem0[ram_addr0];
      if (ram_we0) mem0[ram_addr0] = ram_din0;
   end
   always @(posedge clk) begin
      q1 <= mem1[ram_addr1];
      if (ram_we1) mem1[ram_addr1] = ram_din1;
   end

   // Write strobe monitor for the round-robin instance.
   always @(posedge clk) begin
      if (ram_we0) begin
         we_cnt0  = we_cnt0 + 1;
         we_addr0 = ram_addr0;
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   function automatic logic [7:0] init_val(input int a);
      if (a == 32'h123) return 8'h5A;
      return 8'((a * 37 + 11) ^ (a >> 8));
   endfunction

   function automatic logic wsig(input int sel);
      case (sel)
         0:       return main_wait_n0;
         1:       return sub_wait_n0;
         2:       return main_wait_n1;
         default: return sub_wait_n1;
      endcase
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Bounded wait for a wait_n to go high; returns the number of edges waited.
   task automatic wait_hi(input int sel, input string name, output int n);
      bit done;
      done = 1'b0;
      n = 0;
      for (int k = 0; k < 60 && !done; k++) begin
         @(posedge clk);
         #1;
         n++;
         if (wsig(sel)) done = 1'b1;
      end
      if (!done) begin
         checks++;
         errors++;
         $display("FAIL %s: wait_n still low after %0d clk, required high", name, n);
      end
   endtask

   typedef struct {
      bit            is_sub;
      bit            wr;
      logic [AW-1:0] addr;
      logic [7:0]    din;
      logic [7:0]    exp_dout;
      int            exp_wait;
      int            hold;
   } vec_t;

   vec_t vt [9];

   initial begin
      int w, we_start;
      bit other_hi;

      for (int i = 0; i < 8192; i++) begin
         mem0[i]    = init_val(i);
         mem1[i]    = init_val(i);
         ref_mem[i] = init_val(i);
      end
      rst_n = 1'b0;
      main_cs = 1'b0; main_wrn = 1'b1; main_addr = '0; main_din = '0;
      sub_en = 1'b1; sub_cs = 1'b0; sub_wrn = 1'b1; sub_addr = '0; sub_din = '0;

      // Vectors: {sub?, write?, addr, din, expected dout, expected wait clk, extra hold clk}
      vt[0] = '{1'b0, 1'b0, 13'h0123, 8'h00, 8'h5A, 3, 0};
      vt[1] = '{1'b1, 1'b1, 13'h1FFF, 8'hA5, 8'h00, 3, 3};
      vt[2] = '{1'b0, 1'b0, 13'h1FFF, 8'h00, 8'hA5, 3, 0};
      vt[3] = '{1'b1, 1'b0, 13'h0123, 8'h00, 8'h5A, 3, 0};
      vt[4] = '{1'b0, 1'b1, 13'h0000, 8'h11, 8'h00, 3, 1};
      vt[5] = '{1'b1, 1'b0, 13'h0000, 8'h00, 8'h11, 3, 0};
      vt[6] = '{1'b0, 1'b1, 13'h0123, 8'hC3, 8'h00, 3, 2};
      vt[7] = '{1'b0, 1'b0, 13'h0123, 8'h00, 8'hC3, 3, 0};
      vt[8] = '{1'b1, 1'b0, 13'h1FFF, 8'h00, 8'hA5, 3, 1};

      // Reset state
      #23;
      chk("rst_grant", 32'(grant0), 32'h0);
      chk("rst_main_dout", 32'(main_dout0), 32'hFF);
      chk("rst_sub_dout", 32'(sub_dout0), 32'hFF);
      chk("rst_ram_we", 32'(ram_we0), 32'h0);
      chk("rst_main_wait_n", 32'(main_wait_n0), 32'h1);
      chk("rst_sub_wait_n", 32'(sub_wait_n0), 32'h1);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      idle(2);

      // First tie after reset: main wins, sub granted directly when main leaves
      main_cs = 1'b1; main_addr = 13'h0010;
      sub_cs  = 1'b1; sub_addr  = 13'h1010;
      idle(1);
      chk("tie1_main_first", 32'(grant0), 32'h1);
      chk("prio1_tie1_main", 32'(grant1), 32'h1);
      for (int k = 0; k < 60 && !main_wait_n0; k++) begin
         chk("tie1_sub_waits", 32'(sub_wait_n0), 32'h0);
         idle(1);
      end
      chk("tie1_main_done", 32'(main_wait_n0), 32'h1);
      chk("tie1_main_dout", 32'(main_dout0), 32'(ref_mem[13'h0010]));
      idle(1);
      chk("tie1_sub_still_waits", 32'(sub_wait_n0), 32'h0);
      main_cs = 1'b0;
      idle(1);
      chk("tie1_direct_sub", 32'(grant0), 32'h2);
      wait_hi(1, "tie1_sub_wait", w);
      chk("tie1_sub_dout", 32'(sub_dout0), 32'(ref_mem[13'h1010]));
      sub_cs = 1'b0;
      idle(2);

      // Second tie alternates to sub
      main_cs = 1'b1; main_addr = 13'h0011;
      sub_cs  = 1'b1; sub_addr  = 13'h1011;
      idle(1);
      chk("tie2_sub_first", 32'(grant0), 32'h2);
      chk("prio1_tie2_main", 32'(grant1), 32'h1);
      wait_hi(1, "tie2_sub_wait", w);
      chk("tie2_main_waits", 32'(main_wait_n0), 32'h0);
      sub_cs = 1'b0;
      wait_hi(0, "tie2_main_wait", w);
      chk("tie2_main_dout", 32'(main_dout0), 32'(ref_mem[13'h0011]));
      main_cs = 1'b0;
      idle(2);

      // Fixed priority: repeated ties always go to main, sub fills the gaps
      for (int r = 0; r < 3; r++) begin
         main_cs = 1'b1; main_addr = 13'(32'h20 + r);
         sub_cs  = 1'b1; sub_addr  = 13'(32'h1020 + r);
         idle(1);
         chk($sformatf("prio1_tie%0d_main", r), 32'(grant1), 32'h1);
         wait_hi(2, "prio1_main_wait", w);
         chk($sformatf("prio1_sub_waits%0d", r), 32'(sub_wait_n1), 32'h0);
         main_cs = 1'b0;
         idle(1);
         chk($sformatf("prio1_gap%0d_sub", r), 32'(grant1), 32'h2);
         wait_hi(3, "prio1_sub_wait", w);
         chk($sformatf("prio1_sub_dout%0d", r), 32'(sub_dout1), 32'(ref_mem[32'h1020 + r]));
         sub_cs = 1'b0;
         idle(2);
      end

      // sub_en drops during sub phase 1 while main is pending
      sub_cs = 1'b1; sub_wrn = 1'b1; sub_addr = 13'h1234;
      idle(1);
      chk("suben_grant_sub", 32'(grant0), 32'h2);
      idle(1);
      sub_en = 1'b0; sub_wrn = 1'b0;
      main_cs = 1'b1; main_wrn = 1'b1; main_addr = 13'h0123;
      we_start = we_cnt0;
      chk("suben_no_we", 32'(ram_we0), 32'h0);
      idle(1);
      chk("suben_grant_main", 32'(grant0), 32'h1);
      wait_hi(0, "suben_main_wait", w);
      chk("suben_main_dout", 32'(main_dout0), 32'h5A);
      chk("suben_we_count", 32'(we_cnt0 - we_start), 32'h0);
      main_cs = 1'b0; sub_cs = 1'b0; sub_en = 1'b1; sub_wrn = 1'b1;
      idle(2);

      // Uncontended accesses from the vector table
      for (int i = 0; i < 9; i++) begin
         bit done;
         we_start = we_cnt0;
         other_hi = 1'b1;
         done = 1'b0;
         w = 0;
         if (vt[i].is_sub) begin
            sub_cs = 1'b1; sub_wrn = ~vt[i].wr; sub_addr = vt[i].addr; sub_din = vt[i].din;
         end else begin
            main_cs = 1'b1; main_wrn = ~vt[i].wr; main_addr = vt[i].addr; main_din = vt[i].din;
         end
         for (int k = 0; k < 60 && !done; k++) begin
            @(posedge clk);
            #1;
            w++;
            if (!wsig(vt[i].is_sub ? 0 : 1)) other_hi = 1'b0;
            if (wsig(vt[i].is_sub ? 1 : 0)) done = 1'b1;
         end
         chk($sformatf("vec%0d_wait_clk", i), 32'(w), 32'(vt[i].exp_wait));
         chk($sformatf("vec%0d_other_wait_n", i), 32'(other_hi), 32'h1);
         if (!vt[i].wr) begin
            chk($sformatf("vec%0d_dout", i),
                32'(vt[i].is_sub ? sub_dout0 : main_dout0), 32'(vt[i].exp_dout));
         end
         idle(vt[i].hold);
         main_cs = 1'b0; main_wrn = 1'b1; sub_cs = 1'b0; sub_wrn = 1'b1;
         idle(2);
         chk($sformatf("vec%0d_we_pulses", i), 32'(we_cnt0 - we_start), 32'(vt[i].wr));
         if (vt[i].wr) begin
            chk($sformatf("vec%0d_we_addr", i), 32'(we_addr0), 32'(vt[i].addr));
            ref_mem[vt[i].addr] = vt[i].din;
         end
      end

      // Random concurrent traffic from both CPUs on disjoint address windows
      we_start = we_cnt0;
      fork
         begin
            for (int n = 0; n < 40; n++) begin
               logic [AW-1:0] a;
               logic [7:0]    d;
               bit            wr;
               int            wm;
               idle(int'($urandom_range(1, 3)));
               wr = 1'($urandom_range(0, 1));
               a  = 13'($urandom_range(0, 31));
               d  = 8'($urandom);
               main_addr = a; main_din = d; main_wrn = ~wr; main_cs = 1'b1;
               wait_hi(0, "rand_main_wait", wm);
               if (wr) begin
                  ref_mem[a] = d;
                  wr_total++;
               end else begin
                  chk("rand_main_dout", 32'(main_dout0), 32'(ref_mem[a]));
               end
               idle(int'($urandom_range(0, 2)));
               main_cs = 1'b0; main_wrn = 1'b1;
            end
         end
         begin
            for (int n = 0; n < 40; n++) begin
               logic [AW-1:0] a;
               logic [7:0]    d;
               bit            wr;
               int            ws;
               idle(int'($urandom_range(1, 3)));
               wr = 1'($urandom_range(0, 1));
               a  = 13'(32'h1000 + $urandom_range(0, 31));
               d  = 8'($urandom);
               sub_addr = a; sub_din = d; sub_wrn = ~wr; sub_cs = 1'b1;
               wait_hi(1, "rand_sub_wait", ws);
               if (wr) begin
                  ref_mem[a] = d;
                  wr_total++;
               end else begin
                  chk("rand_sub_dout", 32'(sub_dout0), 32'(ref_mem[a]));
               end
               idle(int'($urandom_range(0, 2)));
               sub_cs = 1'b0; sub_wrn = 1'b1;
            end
         end
      join
      idle(3);
      chk("rand_we_count", 32'(we_cnt0 - we_start), 32'(wr_total));

      // Reset asserted in the middle of a main write access
      main_cs = 1'b1; main_wrn = 1'b0; main_addr = 13'h0050; main_din = 8'h77;
      idle(1);
      chk("midrst_we_phase0", 32'(ram_we0), 32'h1);
      idle(1);
      chk("midrst_we_once", 32'(ram_we0), 32'h0);
      rst_n = 1'b0;
      #1;
      chk("midrst_grant", 32'(grant0), 32'h0);
      chk("midrst_ram_we", 32'(ram_we0), 32'h0);
      chk("midrst_main_dout", 32'(main_dout0), 32'hFF);
      chk("midrst_sub_dout", 32'(sub_dout0), 32'hFF);
      idle(2);
      chk("midrst_we_held", 32'(ram_we0), 32'h0);
      main_cs = 1'b0; main_wrn = 1'b1;
      rst_n = 1'b1;
      idle(2);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
